// File: rtl/simon_game_core.sv
// Simon memory game core: grows a random lamp sequence, plays it back,
// then checks the player's button presses against it with a timeout.
module simon_game_core #(
  parameter int NUM_BUTTONS    = 4,
  parameter int DEPTH          = 16,
  parameter int STEP_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int BW = (NUM_BUTTONS > 2) ? $clog2(NUM_BUTTONS) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BW-1:0]          btn_idx,
  input  logic                   btn_valid,
  input  logic [BW-1:0]          rand_idx,
  output logic [NUM_BUTTONS-1:0] lamp,
  output logic                   busy,
  output logic                   win,
  output logic                   lose,
  output logic [LW-1:0]          level,
  output logic [LW-1:0]          high_score,
  output logic                   hs,
  output logic [2:0]             state_dbg
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PMAX = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BW:0]            NB_X = (BW+1)'(NUM_BUTTONS);
  localparam logic [NUM_BUTTONS-1:0] ONE  = {{(NUM_BUTTONS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_PLAY_ON, S_PLAY_GAP, S_WAIT_IN, S_WIN, S_LOSE
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [LW-1:0]   high_score_q, high_score_d;
  logic            hs_q, hs_d;
  logic [BW-1:0]   mem_q [DEPTH];

  logic            mem_we;
  logic [BW-1:0]   mem_wdata;
  logic [BW-1:0]   cur_sym;
  logic            last_step;
  logic            btn_ok;
  logic            finish;
  logic [LW-1:0]   score;

  assign cur_sym   = mem_q[ptr_q[AW-1:0]];
  assign last_step = ((ptr_q + LW'(1)) == len_q);
  assign btn_ok    = ({1'b0, btn_idx} < NB_X) && (btn_idx == cur_sym);

  // Out-of-range random values are folded back by one NUM_BUTTONS step.
  always_comb begin
    if ({1'b0, rand_idx} < NB_X) mem_wdata = rand_idx;
    else                         mem_wdata = rand_idx - BW'(NUM_BUTTONS);
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    ptr_d        = ptr_q;
    pcnt_d       = pcnt_q;
    tmo_d        = tmo_q;
    high_score_d = high_score_q;
    hs_d         = hs_q;
    mem_we       = 1'b0;
    finish       = 1'b0;
    score        = '0;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          len_d   = '0;
          ptr_d   = '0;
          hs_d    = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        mem_we  = 1'b1;
        len_d   = len_q + LW'(1);
        ptr_d   = '0;
        pcnt_d  = PW'(STEP_CYCLES - 1);
        state_d = S_PLAY_ON;
      end
      S_PLAY_ON: begin
        if (pcnt_q == '0) begin
          pcnt_d  = PW'(GAP_CYCLES - 1);
          state_d = S_PLAY_GAP;
        end else begin
          pcnt_d = pcnt_q - PW'(1);
        end
      end
      S_PLAY_GAP: begin
        if (pcnt_q != '0) begin
          pcnt_d = pcnt_q - PW'(1);
        end else if (!last_step) begin
          ptr_d   = ptr_q + LW'(1);
          pcnt_d  = PW'(STEP_CYCLES - 1);
          state_d = S_PLAY_ON;
        end else begin
          ptr_d   = '0;
          tmo_d   = TW'(TIMEOUT_CYCLES);
          state_d = S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        // A press in the expiry cycle still counts; the timeout only fires on silence.
        if (btn_valid) begin
          if (btn_ok) begin
            tmo_d = TW'(TIMEOUT_CYCLES);
            if (!last_step) begin
              ptr_d = ptr_q + LW'(1);
            end else if (len_q == LW'(DEPTH)) begin
              finish  = 1'b1;
              score   = len_q;
              state_d = S_WIN;
            end else begin
              state_d = S_ADD;
            end
          end else begin
            finish  = 1'b1;
            score   = len_q - LW'(1);
            state_d = S_LOSE;
          end
        end else if (tmo_q == TW'(1)) begin
          finish  = 1'b1;
          score   = len_q - LW'(1);
          state_d = S_LOSE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (finish && (score > high_score_q)) begin
      high_score_d = score;
      hs_d         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      ptr_q        <= '0;
      pcnt_q       <= '0;
      tmo_q        <= '0;
      high_score_q <= '0;
      hs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      ptr_q        <= ptr_d;
      pcnt_q       <= pcnt_d;
      tmo_q        <= tmo_d;
      high_score_q <= high_score_d;
      hs_q         <= hs_d;
    end
  end

  // Sequence storage carries no reset; len bounds what is ever read.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[len_q[AW-1:0]] <= mem_wdata;
  end

  always_comb begin
    lamp = '0;
    case (state_q)
      S_PLAY_ON: lamp = ONE << cur_sym;
      S_WAIT_IN: if (btn_valid) lamp = ONE << btn_idx;
      default:   lamp = '0;
    endcase
  end

  assign busy       = !((state_q == S_IDLE) || (state_q == S_WIN) || (state_q == S_LOSE));
  assign win        = (state_q == S_WIN);
  assign lose       = (state_q == S_LOSE);
  assign level      = len_q;
  assign high_score = high_score_q;
  assign hs         = hs_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_simon_game_core.sv
// Bench for simon_game_core: scenario-level game model builds a per-cycle
// expected output trace, one compare process checks it every cycle.
module tb_simon_game_core;

  localparam int NB   = 3;
  localparam int DEP  = 2;
  localparam int STEP = 3;
  localparam int GAP  = 2;
  localparam int TMO  = 10;
  localparam int BW   = 2;
  localparam int LW   = 2;
  localparam int OW   = NB + 3 + 2*LW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          btn_valid = 1'b0;
  logic [BW-1:0] btn_idx = '0;
  logic [BW-1:0] rand_idx = '0;
  logic [NB-1:0] lamp;
  logic          busy, win, lose, hs;
  logic [LW-1:0] level, high_score;
  logic [2:0]    state_dbg;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  logic [OW-1:0] exp_q[$];
  bit            chk_q[$];

  int m_seq[$];
  int m_ptr, m_len, m_hi;
  bit m_win, m_lose, m_hs;

  always #5 clk = ~clk;

  simon_game_core #(
    .NUM_BUTTONS(NB), .DEPTH(DEP), .STEP_CYCLES(STEP),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn_idx(btn_idx),
    .btn_valid(btn_valid), .rand_idx(rand_idx), .lamp(lamp), .busy(busy),
    .win(win), .lose(lose), .level(level), .high_score(high_score),
    .hs(hs), .state_dbg(state_dbg)
  );

  function automatic logic [NB-1:0] onehot(input int i);
    logic [NB-1:0] r;
    r = '0;
    for (int j = 0; j < NB; j++) if (j == i) r[j] = 1'b1;
    return r;
  endfunction

  function automatic logic [OW-1:0] pack(input logic [NB-1:0] l, input bit b, input bit w,
                                         input bit lo, input int lv, input int hi, input bit h);
    return {l, b, w, lo, LW'(lv), LW'(hi), h};
  endfunction

  function automatic logic [OW-1:0] rest_exp();
    return pack('0, 1'b0, m_win, m_lose, m_len, m_hi, m_hs);
  endfunction

  function automatic logic [OW-1:0] busy_exp(input logic [NB-1:0] l);
    return pack(l, 1'b1, 1'b0, 1'b0, m_len, m_hi, 1'b0);
  endfunction

  always @(negedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      logic [OW-1:0] e, a;
      bit c;
      e = exp_q.pop_front();
      c = chk_q.pop_front();
      a = {lamp, busy, win, lose, level, high_score, hs};
      if (c) begin
        checks++;
        if (a === e) passes++;
        else $display("FAIL trace cycle %0d: {lamp,busy,win,lose,level,hiscore,hs} got %b expected %b",
                      cyc, a, e);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic tick(input bit r, input bit s, input bit v, input int idx, input int rnd,
                      input logic [OW-1:0] e, input bit c);
    @(negedge clk);
    rst       = r;
    start     = s;
    btn_valid = v;
    btn_idx   = BW'(idx);
    rand_idx  = BW'(rnd);
    exp_q.push_back(e);
    chk_q.push_back(c);
  endtask

  task automatic do_reset(input bit chk_first, input logic [OW-1:0] first_exp);
    tick(1'b1, 1'b1, 1'b1, 1, 0, first_exp, chk_first);
    m_seq.delete();
    m_len = 0; m_ptr = 0; m_hi = 0; m_win = 0; m_lose = 0; m_hs = 0;
    tick(1'b1, 1'b1, 1'b1, 1, 0, rest_exp(), 1'b1);
  endtask

  task automatic rest(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 0, 0, rest_exp(), 1'b1);
  endtask

  task automatic start_game();
    tick(1'b0, 1'b1, 1'b0, 0, 0, rest_exp(), 1'b1);
    m_seq.delete();
    m_len = 0; m_ptr = 0; m_hs = 0; m_win = 0; m_lose = 0;
  endtask

  task automatic finish_game(input int score, input bit w);
    m_win  = w;
    m_lose = !w;
    if (score > m_hi) begin m_hi = score; m_hs = 1; end
    else m_hs = 0;
  endtask

  // One round: add a step, then play the whole sequence back. noise injects
  // ignored start/btn pulses; abort resets in the second lamp-on cycle.
  task automatic round(input int rnd, input bit noise, input logic [NB-1:0] lit_lamp, input bit abort);
    tick(1'b0, 1'b0, 1'b0, 0, rnd, busy_exp('0), 1'b1);
    m_seq.push_back((rnd < NB) ? rnd : rnd - NB);
    m_len++;
    for (int i = 0; i < m_seq.size(); i++) begin
      for (int c = 0; c < STEP; c++) begin
        if (abort && i == 0 && c == 1) begin
          do_reset(1'b1, busy_exp(onehot(m_seq[0])));
          return;
        end
        tick(1'b0, 1'b0, noise && c == 1, (m_seq[i] + 1) % NB, 0, busy_exp(onehot(m_seq[i])), 1'b1);
        if (lit_lamp != '0 && i == 0 && c == 0) begin
          #2 lit("norm_lamp", 32'(lamp), 32'(lit_lamp));
        end
      end
      for (int c = 0; c < GAP; c++)
        tick(1'b0, noise && c == 0, 1'b0, 0, 0, busy_exp('0), 1'b1);
    end
    m_ptr = 0;
  endtask

  task automatic press(input int idx, input int idle);
    for (int i = 0; i < idle; i++) tick(1'b0, 1'b0, 1'b0, 0, 0, busy_exp('0), 1'b1);
    tick(1'b0, 1'b0, 1'b1, idx, 0, busy_exp(onehot(idx)), 1'b1);
    if (idx < NB && idx == m_seq[m_ptr]) begin
      if (m_ptr == m_len - 1) begin
        if (m_len == DEP) finish_game(DEP, 1'b1);
        else m_ptr = 0;
      end else begin
        m_ptr++;
      end
    end else begin
      finish_game(m_len - 1, 1'b0);
    end
  endtask

  task automatic timeout();
    for (int i = 0; i < TMO; i++) tick(1'b0, 1'b0, 1'b0, 0, 0, busy_exp('0), 1'b1);
    finish_game(m_len - 1, 1'b0);
  endtask

  initial begin
    m_ptr = 0; m_len = 0; m_hi = 0; m_win = 0; m_lose = 0; m_hs = 0;
    do_reset(1'b0, '0);
    #2 lit("reset_outputs", 32'({lamp, busy, win, lose, level, high_score, hs}), 32'd0);
    lit("reset_state_idle", 32'(state_dbg), 32'd0);
    rest(2);

    // perfect game with ignored start/btn pulses during the first playback
    start_game();
    round(2, 1'b1, '0, 1'b0);
    press(2, 0);
    round(2, 1'b0, '0, 1'b0);
    press(2, 0);
    press(2, 1);
    rest(3);
    #2 lit("win_flags", 32'({win, lose, busy}), 32'b100);
    lit("win_level", 32'(level), 32'd2);
    lit("win_hiscore", 32'(high_score), 32'd2);
    lit("win_hs", 32'(hs), 32'd1);

    // reset in the middle of playback, with start/btn held during reset
    start_game();
    round(1, 1'b0, '0, 1'b1);
    #2 lit("midplay_reset", 32'({lamp, busy, win, lose, level, high_score, hs}), 32'd0);
    rest(2);

    // wrong button after first playback
    start_game();
    round(1, 1'b0, '0, 1'b0);
    press(2, 2);
    rest(2);
    #2 lit("wrong_lose", 32'({lose, level, high_score, hs}), 32'({1'b1, 2'd1, 2'd0, 1'b0}));

    // out-of-range button index
    start_game();
    round(0, 1'b0, '0, 1'b0);
    press(3, 0);
    rest(1);
    #2 lit("range_lose", 32'(lose), 32'd1);

    // normalisation of rand_idx=3 and a new high score on loss
    start_game();
    round(3, 1'b0, 3'b001, 1'b0);
    press(0, 4);
    round(2, 1'b0, '0, 1'b0);
    press(0, 0);
    press(1, 0);
    rest(2);
    #2 lit("record_lose", 32'({lose, level, high_score, hs}), 32'({1'b1, 2'd2, 2'd1, 1'b1}));

    // plain timeout
    start_game();
    round(1, 1'b0, '0, 1'b0);
    timeout();
    rest(2);
    #2 lit("timeout_lose", 32'({lose, level, high_score, hs}), 32'({1'b1, 2'd1, 2'd1, 1'b0}));

    // presses landing in the last timeout cycle, then an equal score
    start_game();
    round(2, 1'b0, '0, 1'b0);
    press(2, TMO - 1);
    round(0, 1'b0, '0, 1'b0);
    press(2, TMO - 1);
    timeout();
    rest(2);
    #2 lit("reload_lose", 32'({lose, level, high_score, hs}), 32'({1'b1, 2'd2, 2'd1, 1'b0}));

    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
